capture_buffer: RTL and testbench

// Parametrised sample capture buffer for the logic analyzer. Samples DATA_W-bit probe

---
 rtl/capture_buffer.sv | 250 +++++++++++++++++++++++++
 tb/tb_capture_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// capture_buffer: logic-analyzer sample capture buffer.
// Samples DATA_W-bit probe words into a DEPTH-entry block-RAM ring. It keeps a
// pre-trigger window of pre_q samples and captures post_q samples starting at the
// trigger sample. It then streams the window out over valid/ready through a
// 2-entry skid buffer.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   clear                   synchronous abort (outranks everything)
//   arm                     start a capture (IDLE/DONE only); latches pre/post counts
//   sample_en, trigger      sample strobe and trigger (trigger qualified by sample_en)
//   data_in                 probe sample
//   pre_count, post_count   pre-trigger window and post-trigger count (incl. trigger)
//   rd_start                stream the captured window (DONE only)
//   out_data/valid/ready/last  readout stream
//   busy, triggered, done, fill_level  status
module capture_buffer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  arm,
    input  logic                  sample_en,
    input  logic                  trigger,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DEPTH_LOG2-1:0] pre_count,
    input  logic [DEPTH_LOG2:0]   post_count,
    input  logic                  rd_start,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   fill_level
);

    localparam int unsigned ADDR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_FILL,
        S_ARMED,
        S_POST,
        S_DONE,
        S_READ
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pre_q;
    logic [CNT_W-1:0]    post_q;
    logic [CNT_W-1:0]    post_left;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   trig_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]    rd_cnt;
    logic                rd_pend;
    logic                pend_last;
    logic [DATA_W-1:0]   ram_q;
    logic [DATA_W-1:0]   sk_data;
    logic                sk_valid;
    logic                sk_last;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                capturing_c;
    logic                wr_en_c;
    logic [CNT_W-1:0]    fill_inc_c;
    logic [CNT_W-1:0]    win_len_c;
    logic                pop_c;
    logic [1:0]          occ_c;
    logic                issue_c;
    logic [CNT_W-1:0]    post_min1_c;
    logic [CNT_W-1:0]    room_c;
    logic [CNT_W-1:0]    post_clamp_c;

    // Write-side and read-credit decode.
    always_comb begin
        capturing_c  = (state == S_PRE_FILL) || (state == S_ARMED) || (state == S_POST);
        wr_en_c      = capturing_c && sample_en && !clear;
        fill_inc_c   = (fill_level == CNT_W'(DEPTH)) ? fill_level : fill_level + CNT_W'(1);
        win_len_c    = CNT_W'(pre_q) + post_q;
        pop_c        = out_valid && out_ready;
        // Outstanding beats: output register, skid register, RAM read in flight.
        occ_c        = 2'(out_valid) + 2'(sk_valid) + 2'(rd_pend);
        issue_c      = (state == S_READ) && (rd_cnt < win_len_c) &&
                       ((occ_c < 2'd2) || ((occ_c == 2'd2) && pop_c));
        post_min1_c  = (post_count == '0) ? CNT_W'(1) : post_count;
        room_c       = CNT_W'(DEPTH) - CNT_W'(pre_count);
        post_clamp_c = (post_min1_c > room_c) ? room_c : post_min1_c;
    end

    // Sample RAM: one write port, one synchronous read port, contents not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= data_in;
        end
        if (issue_c) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // Control FSM, capture pointers and readout skid buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            pre_q      <= '0;
            post_q     <= '0;
            post_left  <= '0;
            wr_ptr     <= '0;
            trig_ptr   <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            rd_pend    <= 1'b0;
            pend_last  <= 1'b0;
            sk_data    <= '0;
            sk_valid   <= 1'b0;
            sk_last    <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            fill_level <= '0;
        end else if (clear) begin
            state      <= S_IDLE;
            pre_q      <= '0;
            post_q     <= '0;
            post_left  <= '0;
            wr_ptr     <= '0;
            trig_ptr   <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            rd_pend    <= 1'b0;
            pend_last  <= 1'b0;
            sk_data    <= '0;
            sk_valid   <= 1'b0;
            sk_last    <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            fill_level <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                fill_level <= fill_inc_c;
            end

            rd_pend   <= issue_c;
            pend_last <= issue_c && (rd_cnt == win_len_c - CNT_W'(1));
            if (issue_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                rd_cnt <= rd_cnt + CNT_W'(1);
            end

            // Skid: refill the output register when it is empty or being consumed.
            if (pop_c || !out_valid) begin
                if (sk_valid) begin
                    out_data  <= sk_data;
                    out_last  <= sk_last;
                    out_valid <= 1'b1;
                    sk_valid  <= rd_pend;
                    sk_data   <= ram_q;
                    sk_last   <= pend_last;
                end else begin
                    out_valid <= rd_pend;
                    out_last  <= rd_pend && pend_last;
                    if (rd_pend) begin
                        out_data <= ram_q;
                    end
                end
            end else if (rd_pend) begin
                sk_valid <= 1'b1;
                sk_data  <= ram_q;
                sk_last  <= pend_last;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state      <= S_PRE_FILL;
                        pre_q      <= pre_count;
                        post_q     <= post_clamp_c;
                        wr_ptr     <= '0;
                        fill_level <= '0;
                        triggered  <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end else if ((state == S_DONE) && rd_start) begin
                        state  <= S_READ;
                        rd_ptr <= trig_ptr - pre_q;
                        rd_cnt <= '0;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
                S_PRE_FILL: begin
                    if ((pre_q == '0) || (wr_en_c && (fill_inc_c >= CNT_W'(pre_q)))) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (wr_en_c && trigger) begin
                        trig_ptr  <= wr_ptr;
                        triggered <= 1'b1;
                        post_left <= post_q - CNT_W'(1);
                        if (post_q == CNT_W'(1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (wr_en_c) begin
                        post_left <= post_left - CNT_W'(1);
                        if (post_left == CNT_W'(1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (pop_c && out_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer at DEPTH=16. Expected beats are queued
// when a readout is requested; a negedge monitor pops and compares accepted beats
// and checks that held data stays stable during stalls.
module tb_capture_buffer;

    localparam int unsigned DW = 8;
    localparam int unsigned AL = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          arm = 1'b0;
    logic          sample_en = 1'b0;
    logic          trigger = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AL-1:0] pre_count = '0;
    logic [AL:0]   post_count = '0;
    logic          rd_start = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AL:0]   fill_level;

    capture_buffer #(.DATA_W(DW), .DEPTH_LOG2(AL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .arm        (arm),
        .sample_en  (sample_en),
        .trigger    (trigger),
        .data_in    (data_in),
        .pre_count  (pre_count),
        .post_count (post_count),
        .rd_start   (rd_start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];
    int         rdy_mode = 0;
    logic       stalled = 1'b0;
    logic [8:0] held;
    logic [8:0] exp_beat;

    // Sink readiness: always ready, or alternating 1,0,1,0...
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else               out_ready = ~out_ready;
    end

    // Monitor: a beat seen valid&ready at negedge is accepted on the next posedge.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (stalled) begin
                n_vec++;
                if ({out_last, out_data} !== held) begin
                    n_bad++;
                    $display("FAIL stall_hold: got last=%0b data=%0d, held last=%0b data=%0d",
                             out_last, out_data, held[8], held[7:0]);
                end
            end
            if (out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: got last=%0b data=%0d, expected no beat",
                             out_last, out_data);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({out_last, out_data} !== exp_beat) begin
                        n_bad++;
                        $display("FAIL beat: got last=%0b data=%0d, expected last=%0b data=%0d",
                                 out_last, out_data, exp_beat[8], exp_beat[7:0]);
                    end
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = {out_last, out_data};
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic arm_cap(input int pre, input int post);
        pre_count  = AL'(pre);
        post_count = (AL + 1)'(post);
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic feed(input int n, input int t1, input int t2);
        for (int k = 0; k < n; k++) begin
            sample_en = 1'b1;
            data_in   = DW'(k);
            trigger   = (k == t1) || (k == t2);
            step();
        end
        sample_en = 1'b0;
        trigger   = 1'b0;
    endtask

    task automatic read_win(input string nm, input int first, input int len);
        for (int k = 0; k < len; k++) begin
            exp_q.push_back({(k == len - 1), DW'(first + k)});
        end
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && done) break;
            step();
        end
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // Reset state.
        step();
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_triggered", 32'(triggered), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_fill", 32'(fill_level), 0);
        reset_n = 1'b1;
        step();

        // Asynchronous reset while in POST.
        arm_cap(2, 8);
        feed(5, 3, -1);
        check("post_busy", 32'(busy), 1);
        check("post_triggered", 32'(triggered), 1);
        check("post_fill", 32'(fill_level), 5);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_triggered", 32'(triggered), 0);
        check("arst_fill", 32'(fill_level), 0);
        check("arst_done", 32'(done), 0);
        step();
        reset_n = 1'b1;
        step();

        // pre=4, post=4, trigger on sample 10 -> 6..13.
        arm_cap(4, 4);
        feed(14, 10, -1);
        check("t2_done", 32'(done), 1);
        check("t2_fill", 32'(fill_level), 14);
        check("t2_triggered", 32'(triggered), 1);
        read_win("t2", 6, 8);

        // pre=3, post=5, trigger on sample 20 -> 17..24 across the wrap.
        arm_cap(3, 5);
        check("t3_triggered_cleared", 32'(triggered), 0);
        feed(25, 20, -1);
        check("t3_fill_sat", 32'(fill_level), 16);
        read_win("t3", 17, 8);

        // pre=8, post=2, early trigger on 3 ignored, trigger on 9 -> 1..10.
        arm_cap(8, 2);
        feed(11, 3, 9);
        check("t4_done", 32'(done), 1);
        read_win("t4", 1, 10);

        // pre=12, post=10 clamped to 4, trigger on 12 -> 0..15.
        arm_cap(12, 10);
        feed(16, 12, -1);
        check("t5_done", 32'(done), 1);
        read_win("t5", 0, 16);

        // Re-read the same window with an alternating sink.
        rdy_mode = 1;
        read_win("t6", 0, 16);
        rdy_mode = 0;
        step();

        // clear mid-read drops out_valid on the next edge.
        for (int k = 0; k < 16; k++) exp_q.push_back({(k == 15), DW'(k)});
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_out_valid", 32'(out_valid), 0);
        check("clr_busy", 32'(busy), 0);
        check("clr_done", 32'(done), 0);
        check("clr_fill", 32'(fill_level), 0);
        exp_q.delete();

        // rd_start outside DONE is ignored.
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        step();
        check("idle_rd_valid", 32'(out_valid), 0);
        check("idle_rd_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
